// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch front end. Holds the PC, issues one word read per cycle
// to instruction memory, and buffers returned words (with their addresses)
// in a 2-entry FIFO whose head feeds decode through a valid/ready handshake.
// A branch redirect reloads the PC, empties the FIFO and drops the response
// that is still on its way back from memory.
//
// Parameters:
//   RESET_VECTOR   PC value loaded on reset
//
// Ports:
//   clk            clock, rising-edge active
//   reset          synchronous active-high reset
//   imem_req       instruction-memory read request this cycle
//   imem_addr      word-aligned read address (current PC)
//   imem_rdata     read data, valid one cycle after imem_req
//   br_taken       one-cycle redirect/flush strobe from execute
//   br_target      redirect address (low two bits ignored)
//   if_valid       head of FIFO holds a valid instruction
//   if_ready       decode accepts the head this cycle
//   if_instr       fetched instruction
//   if_pc          address of if_instr
//   if_pc_plus4    if_pc + 4 (mod 2^32)
//   fetch_count    completed-transfer counter (only with FETCH_CNT_EN)
//
// Build option:
//   `define FETCH_CNT_EN  adds the fetch_count output and its counter.
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
`ifdef FETCH_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    logic [31:0] pc_p0;

    logic        inflight_p1;
    logic [31:0] req_addr_p1;

    logic [31:0] fifo_instr_p2 [2];
    logic [31:0] fifo_pc_p2    [2];
    logic        wr_ptr_p2;
    logic        rd_ptr_p2;
    logic [1:0]  count_p2;

    logic [1:0]  occupancy;
    logic        xfer;
    logic        push;
    logic        req;

    // Occupancy never exceeds 2 because a new request is only issued when
    // there is room, or when the head leaves in the same cycle.
    always_comb begin
        occupancy = count_p2 + {1'b0, inflight_p1};
        xfer      = if_valid && if_ready;
        req       = !reset && !br_taken && ((occupancy < 2'd2) || xfer);
        // A redirect squashes the response arriving in the redirect cycle.
        push      = inflight_p1 && !br_taken;
    end

    assign imem_req    = req;
    assign imem_addr   = pc_p0;
    assign if_valid    = (count_p2 != 2'd0);
    assign if_instr    = fifo_instr_p2[rd_ptr_p2];
    assign if_pc       = fifo_pc_p2[rd_ptr_p2];
    assign if_pc_plus4 = if_pc + 32'd4;

    // ---- stage p0: program counter ----
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0 <= RESET_VECTOR;
        end else if (br_taken) begin
            pc_p0 <= br_target & 32'hFFFF_FFFC;
        end else if (req) begin
            pc_p0 <= pc_p0 + 32'd4;
        end
    end

    // ---- stage p1: request in flight ----
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_p1 <= 1'b0;
        end else begin
            inflight_p1 <= req;
        end
    end

    always_ff @(posedge clk) begin
        if (req) begin
            req_addr_p1 <= pc_p0;
        end
    end

    // ---- stage p2: instruction FIFO ----
    always_ff @(posedge clk) begin
        if (reset || br_taken) begin
            wr_ptr_p2 <= 1'b0;
            rd_ptr_p2 <= 1'b0;
            count_p2  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_p2 <= ~wr_ptr_p2;
            end
            if (xfer) begin
                rd_ptr_p2 <= ~rd_ptr_p2;
            end
            count_p2 <= count_p2 + {1'b0, push} - {1'b0, xfer};
        end
    end

    // Storage is cleared on reset so if_instr/if_pc read as zero while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_instr_p2[i] <= 32'd0;
                fifo_pc_p2[i]    <= 32'd0;
            end
        end else if (push) begin
            fifo_instr_p2[wr_ptr_p2] <= imem_rdata;
            fifo_pc_p2[wr_ptr_p2]    <= req_addr_p1;
        end
    end

`ifdef FETCH_CNT_EN
    // A transfer in the redirect cycle still counts as completed.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= 32'd0;
        end else if (xfer) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. Two instances share the clock: u_dut0 with
// the default reset vector and u_dut1 with a reset vector near the top of
// the address space. Each instruction memory returns addr ^ 32'hA5A5_A5A5
// one cycle after a request. All checks go through check().
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk;

    logic        reset0, reset1;
    logic        imem_req0, imem_req1;
    logic [31:0] imem_addr0, imem_addr1;
    logic [31:0] imem_rdata0, imem_rdata1;
    logic        br_taken0, br_taken1;
    logic [31:0] br_target0, br_target1;
    logic        if_valid0, if_valid1;
    logic        if_ready0, if_ready1;
    logic [31:0] if_instr0, if_instr1;
    logic [31:0] if_pc0, if_pc1;
    logic [31:0] if_pc_plus4_0, if_pc_plus4_1;
`ifdef FETCH_CNT_EN
    logic [31:0] fetch_count0, fetch_count1;
`endif

    int n_checks = 0;
    int n_err    = 0;

    fetch_stage #(.RESET_VECTOR(32'h0000_0000)) u_dut0 (
        .clk(clk), .reset(reset0),
        .imem_req(imem_req0), .imem_addr(imem_addr0), .imem_rdata(imem_rdata0),
        .br_taken(br_taken0), .br_target(br_target0),
        .if_valid(if_valid0), .if_ready(if_ready0),
        .if_instr(if_instr0), .if_pc(if_pc0), .if_pc_plus4(if_pc_plus4_0)
`ifdef FETCH_CNT_EN
        , .fetch_count(fetch_count0)
`endif
    );

    fetch_stage #(.RESET_VECTOR(32'hFFFF_FFF8)) u_dut1 (
        .clk(clk), .reset(reset1),
        .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
        .br_taken(br_taken1), .br_target(br_target1),
        .if_valid(if_valid1), .if_ready(if_ready1),
        .if_instr(if_instr1), .if_pc(if_pc1), .if_pc_plus4(if_pc_plus4_1)
`ifdef FETCH_CNT_EN
        , .fetch_count(fetch_count1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memories: one-cycle read latency.
    always @(posedge clk) imem_rdata0 <= imem_addr0 ^ KEY;
    always @(posedge clk) imem_rdata1 <= imem_addr1 ^ KEY;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 2 time units into cycle 0 (first cycle with reset=0).
    task automatic reset_dut0();
        reset0 = 1'b1;
        step();
        step();
        reset0 = 1'b0;
        #1;
    endtask

    initial begin
        int nreq;
        reset0 = 1'b1; reset1 = 1'b1;
        br_taken0 = 1'b0; br_taken1 = 1'b0;
        br_target0 = 32'd0; br_target1 = 32'd0;
        if_ready0 = 1'b1; if_ready1 = 1'b1;

        // ---- reset state and basic streaming ----
        step();
        step();
        check("rst_valid", {31'd0, if_valid0}, 32'd0);
        check("rst_req", {31'd0, imem_req0}, 32'd0);
        check("rst_addr", imem_addr0, 32'h0);
        check("rst_pc", if_pc0, 32'h0);
        check("rst_instr", if_instr0, 32'h0);
        check("rst_pc4", if_pc_plus4_0, 32'h4);
        reset0 = 1'b0;
        #1;
        check("c0_req", {31'd0, imem_req0}, 32'd1);
        check("c0_addr", imem_addr0, 32'h0);
        step();
        check("c1_addr", imem_addr0, 32'h4);
        check("c1_valid", {31'd0, if_valid0}, 32'd0);
        step();
        check("c2_addr", imem_addr0, 32'h8);
        check("c2_valid", {31'd0, if_valid0}, 32'd1);
        check("c2_pc", if_pc0, 32'h0);
        check("c2_instr", if_instr0, 32'hA5A5_A5A5);
        check("c2_pc4", if_pc_plus4_0, 32'h4);
        step();
        check("c3_pc", if_pc0, 32'h4);
        check("c3_instr", if_instr0, 32'hA5A5_A5A1);
        check("c3_pc4", if_pc_plus4_0, 32'h8);
        step();
        check("c4_pc", if_pc0, 32'h8);
        check("c4_pc4", if_pc_plus4_0, 32'hC);

        // ---- backpressure: decode stalls, FIFO fills, nothing lost ----
        if_ready0 = 1'b0;
        reset_dut0();
        nreq = 0;
        for (int c = 0; c < 7; c++) begin
            nreq += int'(imem_req0);
            if (c >= 2) begin
                check("stall_valid", {31'd0, if_valid0}, 32'd1);
                check("stall_pc", if_pc0, 32'h0);
            end
            if (c < 6) step();
        end
        check("stall_nreq", nreq, 32'd2);
        step();
        if_ready0 = 1'b1;
        #1;
        check("drain0_pc", if_pc0, 32'h0);
        check("drain0_req", {31'd0, imem_req0}, 32'd1);
        check("drain0_addr", imem_addr0, 32'h8);
        step();
        check("drain1_valid", {31'd0, if_valid0}, 32'd1);
        check("drain1_pc", if_pc0, 32'h4);
        step();
        check("drain2_valid", {31'd0, if_valid0}, 32'd1);
        check("drain2_pc", if_pc0, 32'h8);
        check("drain2_instr", if_instr0, 32'hA5A5_A5AD);

        // ---- redirect in steady flow ----
        if_ready0 = 1'b1;
        reset_dut0();
        step();
        step();
        step();
        check("pre_br_pc", if_pc0, 32'h4);
        br_taken0 = 1'b1;
        br_target0 = 32'h0000_1003;
        #1;
        check("br_req", {31'd0, imem_req0}, 32'd0);
        step();
        br_taken0 = 1'b0;
        br_target0 = 32'h0;
        #1;
        check("br1_valid", {31'd0, if_valid0}, 32'd0);
        check("br1_addr", imem_addr0, 32'h0000_1000);
        check("br1_req", {31'd0, imem_req0}, 32'd1);
        step();
        check("br2_valid", {31'd0, if_valid0}, 32'd0);
        step();
        check("br3_valid", {31'd0, if_valid0}, 32'd1);
        check("br3_pc", if_pc0, 32'h0000_1000);
        check("br3_instr", if_instr0, 32'hA5A5_B5A5);
        step();
        check("br4_pc", if_pc0, 32'h0000_1004);

        // ---- PC wrap at the top of the address space ----
        step();
        reset1 = 1'b0;
        #1;
        check("wrap_c0_addr", imem_addr1, 32'hFFFF_FFF8);
        step();
        check("wrap_c1_addr", imem_addr1, 32'hFFFF_FFFC);
        step();
        check("wrap_c2_addr", imem_addr1, 32'h0);
        check("wrap_c2_pc", if_pc1, 32'hFFFF_FFF8);
        check("wrap_c2_pc4", if_pc_plus4_1, 32'hFFFF_FFFC);
        step();
        check("wrap_c3_pc", if_pc1, 32'hFFFF_FFFC);
        check("wrap_c3_pc4", if_pc_plus4_1, 32'h0);
        step();
        check("wrap_c4_pc", if_pc1, 32'h0);
        check("wrap_c4_pc4", if_pc_plus4_1, 32'h4);

        // ---- reset pulse with buffered and in-flight instructions ----
        if_ready0 = 1'b0;
        reset_dut0();
        step();
        step();
        check("mid_valid_before", {31'd0, if_valid0}, 32'd1);
        reset0 = 1'b1;
        step();
        check("mid_rst_valid", {31'd0, if_valid0}, 32'd0);
        check("mid_rst_req", {31'd0, imem_req0}, 32'd0);
        check("mid_rst_pc", if_pc0, 32'h0);
        reset0 = 1'b0;
        if_ready0 = 1'b1;
        #1;
        check("mid_rel_req", {31'd0, imem_req0}, 32'd1);
        check("mid_rel_addr", imem_addr0, 32'h0);
        step();
        check("mid_rel1_valid", {31'd0, if_valid0}, 32'd0);
        step();
        check("mid_rel2_valid", {31'd0, if_valid0}, 32'd1);
        check("mid_rel2_pc", if_pc0, 32'h0);

`ifdef FETCH_CNT_EN
        // ---- transfer counter across a redirect ----
        begin
            int xfers;
            int cyc;
            if_ready0 = 1'b1;
            reset_dut0();
            check("cnt_after_rst", fetch_count0, 32'd0);
            xfers = 0;
            cyc = 0;
            while (xfers < 10 && cyc < 200) begin
                br_taken0 = (cyc == 5);
                br_target0 = 32'h0000_2000;
                #1;
                if (if_valid0 && if_ready0) xfers++;
                step();
                cyc++;
            end
            br_taken0 = 1'b0;
            if_ready0 = 1'b0;
            #1;
            check("cnt_xfers_seen", xfers, 32'd10);
            check("cnt_value", fetch_count0, 32'd10);
            reset0 = 1'b1;
            step();
            check("cnt_cleared", fetch_count0, 32'd0);
            reset0 = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
